// File: rtl/shift_seq.sv
// Sequencer for the shared 16-bit shifter: accepts one shift/rotate/LUI request at a
// time, runs one or two passes through the external shifter and returns the result.
module shift_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [2:0]       op,
    input  logic [3:0]       amount,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] sh_in,
    output logic [4:0]       sh_amount,
    output logic             sh_lui,
    input  logic [WIDTH-1:0] sh_out,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PASS1 = 2'b01,
        PASS2 = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_ROL = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_LUI = 3'b100;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [2:0]       op_q, op_d;
    logic [3:0]       k_q, k_d;
    logic             is_rot;

    assign is_rot = (op_q == OP_ROL) || (op_q == OP_ROR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            opnd_q  <= '0;
            acc_q   <= '0;
            op_q    <= '0;
            k_q     <= '0;
        end else begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            state_q <= state_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first, so no path infers a latch.
        state_d = state_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        op_d    = op_q;
        k_d     = k_q;
        unique case (state_q)
            IDLE: begin
                if (start_valid) begin
                    state_d = PASS1;
                    opnd_d  = data_in;
                    op_d    = op;
                    // A right rotate by k is a left rotate by (16-k) mod 16.
                    k_d     = (op == OP_ROR) ? (4'd0 - amount) : amount;
                    acc_d   = '0;
                end
            end
            PASS1: begin
                acc_d   = sh_out;
                state_d = is_rot ? PASS2 : DONE;
            end
            PASS2: begin
                acc_d   = acc_q | sh_out;
                state_d = DONE;
            end
            DONE: begin
                if (result_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Shifter drive is decoded purely from registered state.
    always_comb begin
        sh_in     = '0;
        sh_amount = 5'd0;
        sh_lui    = 1'b0;
        unique case (state_q)
            PASS1: begin
                sh_in = opnd_q;
                unique case (op_q)
                    OP_SLL, OP_ROL, OP_ROR: sh_amount = {1'b0, k_q};
                    OP_SRL:                 sh_amount = 5'd0 - {1'b0, k_q};
                    OP_LUI:                 sh_lui    = 1'b1;
                    default:                sh_amount = 5'd0;
                endcase
            end
            PASS2: begin
                // Right shift by 16-k; k=0 becomes -16, which the shifter zeroes.
                sh_in     = opnd_q;
                sh_amount = {1'b1, k_q};
            end
            default: ;
        endcase
    end

    assign start_ready  = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign result_valid = (state_q == DONE);
    assign result       = acc_q;

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq with a behavioural model of the combinational shifter.
module tb_shift_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_valid;
    logic        start_ready;
    logic [2:0]  op;
    logic [3:0]  amount;
    logic [15:0] data_in;
    logic [15:0] sh_in;
    logic [4:0]  sh_amount;
    logic        sh_lui;
    logic [15:0] sh_out;
    logic [15:0] result;
    logic        result_valid;
    logic        result_ready;
    logic        busy;

    typedef struct {
        logic [15:0] res;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   lui_cnt = 0;
    logic prev_valid = 1'b0;

    shift_seq #(.WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .op(op), .amount(amount), .data_in(data_in),
        .sh_in(sh_in), .sh_amount(sh_amount), .sh_lui(sh_lui), .sh_out(sh_out),
        .result(result), .result_valid(result_valid), .result_ready(result_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Shifter contract: 5-bit signed amount, negative = logical right, -16 = 0.
    always_comb begin
        if (sh_lui)            sh_out = {sh_in[7:0], 8'h00};
        else if (sh_amount[4]) sh_out = sh_in >> (6'd32 - {1'b0, sh_amount});
        else                   sh_out = sh_in << sh_amount[3:0];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares whenever the DUT presents a result.
    initial begin
        forever begin
            @(negedge clk);
            if (sh_lui) lui_cnt++;
            if (!busy || result_valid)
                check("sh_drive_idle_done", {10'd0, sh_in, sh_amount, sh_lui}, 32'd0);
            if (result_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %h with nothing outstanding", result);
                end else begin
                    if (!prev_valid) check("latency", cyc - sb[0].acc_cyc, sb[0].lat);
                    check("result", {16'd0, result}, {16'd0, sb[0].res});
                    check("start_ready_in_done", {31'd0, start_ready}, 32'd0);
                    if (result_ready) void'(sb.pop_front());
                end
            end
            prev_valid = result_valid;
        end
    end

    task automatic issue(input logic [2:0] o, input logic [3:0] a, input logic [15:0] d,
                         input logic [15:0] r, input int lat);
        exp_t e;
        check("start_ready_idle", {31'd0, start_ready}, 32'd1);
        op          = o;
        amount      = a;
        data_in     = d;
        start_valid = 1'b1;
        e.res = r; e.lat = lat; e.acc_cyc = cyc;
        sb.push_back(e);
        @(posedge clk); #1;
        start_valid = 1'b0;
        data_in     = 16'hDEAD;
        op          = 3'b000;
        amount      = 4'hF;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d results outstanding after 20 cycles", sb.size());
            sb.delete();
        end
        check("start_ready_after", {31'd0, start_ready}, 32'd1);
        check("busy_after", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int lui_before;
        int n;
        reset_n      = 1'b0;
        start_valid  = 1'b0;
        op           = 3'b000;
        amount       = 4'd0;
        data_in      = 16'h0000;
        result_ready = 1'b1;
        #1;
        check("rst_result", {16'd0, result}, 32'd0);
        check("rst_result_valid", {31'd0, result_valid}, 32'd0);
        check("rst_start_ready", {31'd0, start_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sh", {10'd0, sh_in, sh_amount, sh_lui}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        issue(3'b000, 4'd3, 16'h8001, 16'h0008, 2);
        check("sll_amt", {27'd0, sh_amount}, 32'h03);
        wait_done();

        issue(3'b001, 4'd14, 16'h8001, 16'h0002, 2);
        check("srl14_amt", {27'd0, sh_amount}, 32'h12);
        wait_done();

        issue(3'b001, 4'd0, 16'h8001, 16'h8001, 2);
        check("srl0_amt", {27'd0, sh_amount}, 32'h00);
        wait_done();

        issue(3'b010, 4'd3, 16'h8001, 16'h000C, 3);
        check("rol_pass1_amt", {27'd0, sh_amount}, 32'h03);
        @(posedge clk); #1;
        check("rol_pass2_amt", {27'd0, sh_amount}, 32'h13);
        wait_done();

        issue(3'b010, 4'd0, 16'h8001, 16'h8001, 3);
        wait_done();

        issue(3'b011, 4'd1, 16'h8001, 16'hC000, 3);
        check("ror1_pass1_amt", {27'd0, sh_amount}, 32'h0F);
        wait_done();

        issue(3'b011, 4'd4, 16'h1234, 16'h4123, 3);
        wait_done();

        lui_before = lui_cnt;
        issue(3'b100, 4'd7, 16'h8001, 16'h0100, 2);
        check("lui_flag", {31'd0, sh_lui}, 32'd1);
        wait_done();
        check("lui_cycles", lui_cnt - lui_before, 32'd1);

        issue(3'b111, 4'd5, 16'hBEEF, 16'hBEEF, 2);
        wait_done();
        issue(3'b101, 4'd9, 16'h1357, 16'h1357, 2);
        wait_done();

        // Backpressure: result held, new requests ignored.
        result_ready = 1'b0;
        issue(3'b000, 4'd3, 16'h8001, 16'h0008, 2);
        n = 0;
        while (!result_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_valid_reached", {31'd0, result_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            start_valid = 1'b1;
            op          = 3'b010;
            data_in     = 16'h1111;
            amount      = 4'd2;
            @(posedge clk); #1;
            check("bp_start_ready", {31'd0, start_ready}, 32'd0);
            check("bp_result_valid", {31'd0, result_valid}, 32'd1);
        end
        start_valid  = 1'b0;
        result_ready = 1'b1;
        wait_done();
        repeat (4) begin
            @(posedge clk); #1;
            check("bp_no_extra_op", {31'd0, busy}, 32'd0);
        end

        // Reset during ROL PASS2 discards the operation.
        issue(3'b010, 4'd3, 16'h8001, 16'h000C, 3);
        @(posedge clk); #1;
        check("rst_mid_pass2_amt", {27'd0, sh_amount}, 32'h13);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_result_valid", {31'd0, result_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_start_ready", {31'd0, start_ready}, 32'd1);
        check("midrst_sh", {10'd0, sh_in, sh_amount, sh_lui}, 32'd0);
        sb.delete();
        repeat (2) begin
            @(posedge clk); #1;
            check("midrst_hold_ready", {31'd0, start_ready}, 32'd1);
            check("midrst_hold_result", {16'd0, result}, 32'd0);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_busy", {31'd0, busy}, 32'd0);

        issue(3'b000, 4'd1, 16'h00FF, 16'h01FE, 2);
        wait_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
